// File: rtl/mem_burst_splitter_pkg.sv
// Shared types and constants for the burst-splitting MemDPI front end.
package mem_burst_splitter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRdData,
    StWrData,
    StDone
  } state_e;

  localparam logic OPC_RD = 1'b0;
  localparam logic OPC_WR = 1'b1;

endpackage

// File: rtl/mem_burst_splitter.sv
// Splits one long read/write command into MemDPI bursts of at most MAX_BURST beats
// and bridges data beats between MemDPI and the compute-side ready/valid streams.
module mem_burst_splitter
  import mem_burst_splitter_pkg::*;
#(
  parameter int unsigned MEM_LEN_BITS  = 8,
  parameter int unsigned MEM_ADDR_BITS = 64,
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned MAX_BURST     = 16
) (
  input  logic                     clock,
  input  logic                     reset,

  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_opcode,
  input  logic [MEM_ADDR_BITS-1:0] cmd_addr,
  input  logic [31:0]              cmd_len,
  output logic                     done,

  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [MEM_DATA_BITS-1:0] rd_bits,

  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [MEM_DATA_BITS-1:0] wr_bits,

  output logic                     mem_req_valid,
  output logic                     mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]  mem_req_len,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,

  output logic                     mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0] mem_wr_bits,

  input  logic                     mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  output logic                     mem_rd_ready
);

  localparam int unsigned CntW      = MEM_LEN_BITS + 1;
  localparam int unsigned BeatBytes = MEM_DATA_BITS / 8;

  state_e                   state_q, state_d;
  logic                     opcode_q, opcode_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]              remaining_q, remaining_d;
  logic [CntW-1:0]          burst_q, burst_d;
  logic [CntW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [CntW-1:0]          burst;
  logic                     beat_fire;

  assign burst = (remaining_q < 32'(MAX_BURST)) ? CntW'(remaining_q) : CntW'(MAX_BURST);

  // Data buses are plain pass-throughs; only the handshakes are gated by state.
  assign rd_bits     = mem_rd_bits;
  assign mem_wr_bits = wr_bits;

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    burst_d        = burst_q;
    beat_cnt_d     = beat_cnt_q;
    beat_fire      = 1'b0;
    cmd_ready      = 1'b0;
    done           = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_opcode = OPC_RD;
    mem_req_len    = '0;
    mem_req_addr   = '0;
    rd_valid       = 1'b0;
    mem_rd_ready   = 1'b0;
    wr_ready       = 1'b0;
    mem_wr_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          opcode_d    = cmd_opcode;
          addr_d      = cmd_addr;
          remaining_d = cmd_len;
          state_d     = (cmd_len == 32'd0) ? StDone : StReq;
        end
      end
      StReq: begin
        mem_req_valid  = 1'b1;
        mem_req_opcode = opcode_q;
        mem_req_len    = MEM_LEN_BITS'(burst - CntW'(1));
        mem_req_addr   = addr_q;
        burst_d        = burst;
        beat_cnt_d     = burst;
        state_d        = (opcode_q == OPC_WR) ? StWrData : StRdData;
      end
      StRdData: begin
        rd_valid     = mem_rd_valid;
        mem_rd_ready = rd_ready;
        beat_fire    = mem_rd_valid & rd_ready;
      end
      StWrData: begin
        wr_ready     = 1'b1;
        mem_wr_valid = wr_valid;
        beat_fire    = wr_valid;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (beat_fire) begin
      beat_cnt_d = beat_cnt_q - CntW'(1);
      if (beat_cnt_q == CntW'(1)) begin
        remaining_d = remaining_q - 32'(burst_q);
        // Address wraps modulo 2^MEM_ADDR_BITS by construction.
        addr_d      = addr_q + MEM_ADDR_BITS'(burst_q) * MEM_ADDR_BITS'(BeatBytes);
        state_d     = (remaining_d != 32'd0) ? StReq : StDone;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      opcode_q    <= OPC_RD;
      addr_q      <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_splitter.sv
// Directed self-checking bench for mem_burst_splitter (default parameters).
module tb_mem_burst_splitter;
  import mem_burst_splitter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_opcode, done;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_len;
  logic        rd_valid, rd_ready, wr_valid, wr_ready;
  logic [63:0] rd_bits, wr_bits;
  logic        mem_req_valid, mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [63:0] mem_req_addr;
  logic        mem_wr_valid, mem_rd_valid, mem_rd_ready;
  logic [63:0] mem_wr_bits, mem_rd_bits;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  mem_burst_splitter dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_opcode    (cmd_opcode),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .done          (done),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_bits       (rd_bits),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_bits       (wr_bits),
    .mem_req_valid (mem_req_valid),
    .mem_req_opcode(mem_req_opcode),
    .mem_req_len   (mem_req_len),
    .mem_req_addr  (mem_req_addr),
    .mem_wr_valid  (mem_wr_valid),
    .mem_wr_bits   (mem_wr_bits),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_bits   (mem_rd_bits),
    .mem_rd_ready  (mem_rd_ready)
  );

  // Present a command on the next falling edge; it is accepted at the following rising edge.
  task automatic issue_cmd(input logic opc, input logic [63:0] addr, input logic [31:0] len);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_opcode = opc; cmd_addr = addr; cmd_len = len;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fails++; $display("FAIL issue_cmd_ready: got %0b expected 1", cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if ({cmd_ready, done, mem_req_valid, mem_wr_valid, mem_rd_ready, rd_valid, wr_ready,
         mem_req_opcode} !== 8'b1000_0000) begin
      n_fails++; $display("FAIL reset_ctrl: got %b expected 10000000",
        {cmd_ready, done, mem_req_valid, mem_wr_valid, mem_rd_ready, rd_valid, wr_ready,
         mem_req_opcode});
    end
    n_checks++;
    if (mem_req_len !== 8'd0 || mem_req_addr !== 64'd0) begin
      n_fails++; $display("FAIL reset_req_fields: got len %0h addr %0h expected 0 0",
        mem_req_len, mem_req_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_long();
    logic [63:0] exp_addr [3] = '{64'h1000, 64'h1080, 64'h1100};
    logic [7:0]  exp_len  [3] = '{8'd15, 8'd15, 8'd7};
    int k = 0, reqs = 0, first_req = -1, beat_last = -1, done_cyc = -1, done_cnt = 0;
    mem_rd_valid = 1'b1; rd_ready = 1'b1;
    issue_cmd(OPC_RD, 64'h1000, 32'd40);
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      cmd_valid = 1'b0; mem_rd_bits = 64'hA000 + 64'(k);
      #1;
      if (mem_req_valid) begin
        if (reqs < 3) begin
          n_checks++;
          if (mem_req_addr !== exp_addr[reqs] || mem_req_len !== exp_len[reqs] ||
              mem_req_opcode !== OPC_RD) begin
            n_fails++; $display("FAIL rd_long_req%0d: got addr %0h len %0d opc %0b expected %0h %0d 0",
              reqs, mem_req_addr, mem_req_len, mem_req_opcode, exp_addr[reqs], exp_len[reqs]);
          end
        end
        n_checks++;
        if (rd_valid !== 1'b0) begin
          n_fails++; $display("FAIL rd_long_stray_valid: got %0b expected 0", rd_valid);
        end
        if (reqs == 0) first_req = c;
        reqs++;
      end
      if (rd_valid && mem_rd_ready) begin
        n_checks++;
        if (rd_bits !== 64'hA000 + 64'(k)) begin
          n_fails++; $display("FAIL rd_long_data: got %0h expected %0h", rd_bits, 64'hA000 + 64'(k));
        end
        k++;
        if (k == 40) beat_last = c;
      end
      if (done) begin done_cnt++; done_cyc = c; end
    end
    n_checks++;
    if (reqs !== 3 || k !== 40) begin
      n_fails++; $display("FAIL rd_long_counts: got reqs %0d beats %0d expected 3 40", reqs, k);
    end
    n_checks++;
    if (first_req !== 0 || beat_last !== 42 || done_cyc !== 43 || done_cnt !== 1) begin
      n_fails++; $display("FAIL rd_long_timing: got req %0d last %0d done %0d x%0d expected 0 42 43 x1",
        first_req, beat_last, done_cyc, done_cnt);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fails++; $display("FAIL rd_long_idle: got %0b expected 1", cmd_ready);
    end
    mem_rd_valid = 1'b0;
  endtask

  task automatic test_write();
    int k = 0, reqs = 0, beat_last = -1, done_cyc = -1, done_cnt = 0;
    wr_valid = 1'b1;
    issue_cmd(OPC_WR, 64'h2000, 32'd16);
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      cmd_valid = 1'b0; wr_bits = 64'hB000 + 64'(k);
      #1;
      if (mem_req_valid) begin
        n_checks++;
        if (mem_req_addr !== 64'h2000 || mem_req_len !== 8'd15 || mem_req_opcode !== OPC_WR ||
            mem_wr_valid !== 1'b0 || wr_ready !== 1'b0) begin
          n_fails++; $display("FAIL wr_req: got addr %0h len %0d opc %0b wv %0b wr %0b expected 2000 15 1 0 0",
            mem_req_addr, mem_req_len, mem_req_opcode, mem_wr_valid, wr_ready);
        end
        reqs++;
      end
      if (mem_wr_valid) begin
        n_checks++;
        if (mem_wr_bits !== 64'hB000 + 64'(k) || wr_ready !== 1'b1) begin
          n_fails++; $display("FAIL wr_data: got %0h rdy %0b expected %0h 1",
            mem_wr_bits, wr_ready, 64'hB000 + 64'(k));
        end
        k++;
        if (k == 16) beat_last = c;
      end
      if (done) begin done_cnt++; done_cyc = c; end
    end
    n_checks++;
    if (reqs !== 1 || k !== 16 || beat_last !== 16 || done_cyc !== 17 || done_cnt !== 1) begin
      n_fails++; $display("FAIL wr_summary: got reqs %0d beats %0d last %0d done %0d x%0d expected 1 16 16 17 x1",
        reqs, k, beat_last, done_cyc, done_cnt);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_zero_len();
    issue_cmd(OPC_RD, 64'h10, 32'd0);
    @(negedge clock);
    cmd_valid = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b1 || mem_req_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fails++; $display("FAIL zero_len_t1: got done %0b req %0b rdy %0b expected 1 0 0",
        done, mem_req_valid, cmd_ready);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (done !== 1'b0 || mem_req_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fails++; $display("FAIL zero_len_t2: got done %0b req %0b rdy %0b expected 0 0 1",
        done, mem_req_valid, cmd_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    int k = 0, beat_last = -1, done_cyc = -1;
    mem_rd_valid = 1'b1;
    issue_cmd(OPC_RD, 64'h6000, 32'd4);
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      rd_ready = (c == 0) ? 1'b1 : pat[(c - 1) % 4];
      mem_rd_bits = 64'hC000 + 64'(k);
      #1;
      n_checks++;
      if (c >= 1 && c <= 8) begin
        if (mem_rd_ready !== rd_ready) begin
          n_fails++; $display("FAIL bp_mirror c%0d: got %0b expected %0b", c, mem_rd_ready, rd_ready);
        end
      end else if (mem_rd_ready !== 1'b0) begin
        n_fails++; $display("FAIL bp_gated c%0d: got %0b expected 0", c, mem_rd_ready);
      end
      if (rd_valid && mem_rd_ready) begin
        n_checks++;
        if (rd_bits !== 64'hC000 + 64'(k)) begin
          n_fails++; $display("FAIL bp_data: got %0h expected %0h", rd_bits, 64'hC000 + 64'(k));
        end
        k++;
        beat_last = c;
      end
      if (done) done_cyc = c;
    end
    n_checks++;
    if (k !== 4 || beat_last !== 8 || done_cyc !== 9) begin
      n_fails++; $display("FAIL bp_summary: got beats %0d last %0d done %0d expected 4 8 9",
        k, beat_last, done_cyc);
    end
    mem_rd_valid = 1'b0; rd_ready = 1'b1;
  endtask

  task automatic test_busy_cmd();
    int reqs = 0, done_cnt = 0, done0 = -1, done1 = -1, wr_beats = 0;
    mem_rd_valid = 1'b1; rd_ready = 1'b1; wr_valid = 1'b1; wr_bits = 64'hD00D;
    issue_cmd(OPC_RD, 64'h3000, 32'd2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      cmd_opcode = OPC_WR; cmd_addr = 64'h4000; cmd_len = 32'd1;
      if (c == 5) cmd_valid = 1'b0;
      #1;
      if (c <= 4) begin
        n_checks++;
        if (cmd_ready !== (c == 4)) begin
          n_fails++; $display("FAIL busy_ready c%0d: got %0b expected %0b", c, cmd_ready, c == 4);
        end
      end
      if (mem_req_valid) begin
        reqs++;
        n_checks++;
        if (reqs == 1 && (c !== 0 || mem_req_opcode !== OPC_RD || mem_req_addr !== 64'h3000 ||
                          mem_req_len !== 8'd1)) begin
          n_fails++; $display("FAIL busy_req1: got c%0d opc %0b addr %0h len %0d expected c0 0 3000 1",
            c, mem_req_opcode, mem_req_addr, mem_req_len);
        end else if (reqs == 2 && (c !== 5 || mem_req_opcode !== OPC_WR ||
                                   mem_req_addr !== 64'h4000 || mem_req_len !== 8'd0)) begin
          n_fails++; $display("FAIL busy_req2: got c%0d opc %0b addr %0h len %0d expected c5 1 4000 0",
            c, mem_req_opcode, mem_req_addr, mem_req_len);
        end
      end
      if (mem_wr_valid) begin
        wr_beats++;
        n_checks++;
        if (mem_wr_bits !== 64'hD00D) begin
          n_fails++; $display("FAIL busy_wr_bits: got %0h expected d00d", mem_wr_bits);
        end
      end
      if (done) begin
        if (done_cnt == 0) done0 = c; else done1 = c;
        done_cnt++;
      end
    end
    n_checks++;
    if (reqs !== 2 || done_cnt !== 2 || done0 !== 3 || done1 !== 7 || wr_beats !== 1) begin
      n_fails++; $display("FAIL busy_summary: got reqs %0d dones %0d at %0d,%0d wr %0d expected 2 2 at 3,7 wr 1",
        reqs, done_cnt, done0, done1, wr_beats);
    end
    mem_rd_valid = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_addr_wrap();
    int reqs = 0, done_cyc = -1;
    mem_rd_valid = 1'b1; rd_ready = 1'b1;
    issue_cmd(OPC_RD, 64'hFFFF_FFFF_FFFF_FFC0, 32'd20);
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      #1;
      if (mem_req_valid) begin
        reqs++;
        if (reqs == 2) begin
          n_checks++;
          if (c !== 17 || mem_req_addr !== 64'h40 || mem_req_len !== 8'd3) begin
            n_fails++; $display("FAIL wrap_req2: got c%0d addr %0h len %0d expected c17 40 3",
              c, mem_req_addr, mem_req_len);
          end
        end
      end
      if (done) done_cyc = c;
    end
    n_checks++;
    if (reqs !== 2 || done_cyc !== 22) begin
      n_fails++; $display("FAIL wrap_summary: got reqs %0d done %0d expected 2 22", reqs, done_cyc);
    end
    mem_rd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    mem_rd_valid = 1'b1; rd_ready = 1'b1;
    issue_cmd(OPC_RD, 64'h1000, 32'd40);
    for (int c = 0; c <= 20; c++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      if (c == 20) reset = 1'b1;
      #1;
      if (done) done_cnt++;
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, done, mem_req_valid, mem_wr_valid, mem_rd_ready, rd_valid, wr_ready,
         mem_req_opcode} !== 8'b1000_0000 || mem_req_len !== 8'd0 || mem_req_addr !== 64'd0) begin
      n_fails++; $display("FAIL mid_reset_outputs: got %b len %0d addr %0h expected 10000000 0 0",
        {cmd_ready, done, mem_req_valid, mem_wr_valid, mem_rd_ready, rd_valid, wr_ready,
         mem_req_opcode}, mem_req_len, mem_req_addr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      if (done) done_cnt++;
    end
    n_checks++;
    if (done_cnt !== 0) begin
      n_fails++; $display("FAIL mid_reset_no_done: got %0d expected 0", done_cnt);
    end
    issue_cmd(OPC_RD, 64'h5000, 32'd1);
    mem_rd_bits = 64'hE1;
    @(negedge clock);
    cmd_valid = 1'b0;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h5000 || mem_req_len !== 8'd0) begin
      n_fails++; $display("FAIL mid_reset_req: got v %0b addr %0h len %0d expected 1 5000 0",
        mem_req_valid, mem_req_addr, mem_req_len);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (rd_valid !== 1'b1 || mem_rd_ready !== 1'b1 || rd_bits !== 64'hE1) begin
      n_fails++; $display("FAIL mid_reset_beat: got v %0b r %0b bits %0h expected 1 1 e1",
        rd_valid, mem_rd_ready, rd_bits);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fails++; $display("FAIL mid_reset_done: got %0b expected 1", done);
    end
    mem_rd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = 1'b0; cmd_addr = '0; cmd_len = '0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_bits = '0; mem_rd_valid = 1'b0; mem_rd_bits = '0;
    test_reset();
    test_read_long();
    test_write();
    test_zero_len();
    test_backpressure();
    test_busy_cmd();
    test_addr_wrap();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
